// File: rtl/ss_display_ctrl.sv
// Scan controller and source arbiter for an 8-digit multiplexed 7-segment display.
// Live data is shown by default; a message preempts it for a fixed number of frames.
module ss_display_ctrl #(
   parameter int REFRESH_DIV = 12500,
   parameter int HOLD_FRAMES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  bright,
   input  logic        blank_lz,
   input  logic [31:0] live_bcd,
   input  logic [7:0]  live_dots,
   input  logic        msg_req,
   input  logic [31:0] msg_bcd,
   input  logic [7:0]  msg_dots,
   output logic        msg_ack,
   output logic        msg_busy,
   output logic        frame_tick,
   output logic [7:0]  ss_value,
   output logic [7:0]  ss_select
);

   localparam int SUB = REFRESH_DIV / 16;
   localparam int PW  = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {LIVE, MSG_PEND, MSG_SHOW} state_t;

   state_t        state, state_nx;
   logic [15:0]   hold, hold_nx;
   logic [PW-1:0] prescaler;
   logic [2:0]    digit;
   logic          slot_end, frame_end, take, snap_msg, lit, blanked;
   logic [31:0]   buf_bcd, snap_bcd;
   logic [7:0]    buf_dots, snap_dots;
   logic [8:0]    lz;
   logic [3:0]    cur_nib;
   logic          cur_dot;

   // Active-low {g,f,e,d,c,b,a} pattern; codes 10..15 render as hex A..F.
   function automatic logic [6:0] bcd_to_ss(input logic [3:0] code);
      logic [6:0] on;
      case (code)
         4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
         4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
         4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
         4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
      endcase
      return ~on;
   endfunction

   assign slot_end   = (prescaler == P_LAST);
   assign frame_end  = slot_end && (digit == 3'd7);
   assign frame_tick = frame_end;
   assign msg_busy   = (state != LIVE);
   // The cycle right after an ack ignores the still-high request.
   assign take       = msg_req && !msg_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         digit     <= 3'd0;
      end else begin
         prescaler <= slot_end ? '0 : prescaler + 1'b1;
         if (slot_end) digit <= digit + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LIVE;
         hold  <= 16'd0;
      end else begin
         state <= state_nx;
         hold  <= hold_nx;
      end
   end

   // snap_msg: on a frame boundary, reload from the message buffer rather than live data.
   always_comb begin
      state_nx = state;
      hold_nx  = hold;
      snap_msg = 1'b0;
      case (state)
         LIVE: begin
            if (take) state_nx = MSG_PEND;
         end
         MSG_PEND: begin
            snap_msg = 1'b1;
            if (!take && frame_end) begin
               state_nx = MSG_SHOW;
               hold_nx  = 16'(HOLD_FRAMES);
            end
         end
         MSG_SHOW: begin
            snap_msg = take || (hold != 16'd1);
            if (take) begin
               state_nx = MSG_PEND;
            end else if (frame_end) begin
               if (hold == 16'd1) state_nx = LIVE;
               else               hold_nx  = hold - 16'd1;
            end
         end
         default: state_nx = LIVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (take) begin
         buf_bcd  <= msg_bcd;
         buf_dots <= msg_dots;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_bcd  <= 32'd0;
         snap_dots <= 8'd0;
      end else if (frame_end) begin
         snap_bcd  <= snap_msg ? buf_bcd  : live_bcd;
         snap_dots <= snap_msg ? buf_dots : live_dots;
      end
   end

   // lz[i]: digit i and every digit above it are zero with no DP set.
   always_comb begin : lz_scan
      logic run;
      run = 1'b1;
      lz  = '0;
      lz[8] = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         run   = run && (snap_bcd[4*i +: 4] == 4'd0) && !snap_dots[i];
         lz[i] = run;
      end
   end

   assign cur_nib = snap_bcd[{digit, 2'b00} +: 4];
   assign cur_dot = snap_dots[digit];
   assign blanked = blank_lz && (digit != 3'd0) && lz[digit];
   assign lit     = 32'(prescaler) < (32'(bright) + 32'd1) * 32'(SUB);

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_select <= 8'hFF;
         ss_value  <= 8'hFF;
         msg_ack   <= 1'b0;
      end else begin
         ss_select <= lit ? ~(8'd1 << digit) : 8'hFF;
         ss_value  <= (!lit || blanked) ? 8'hFF : {~cur_dot, bcd_to_ss(cur_nib)};
         msg_ack   <= take;
      end
   end

endmodule

// File: tb/tb_ss_display_ctrl.sv
// Bench for ss_display_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a frame/time-based reference model.
module tb_ss_display_ctrl;

   localparam int DIV  = 16;
   localparam int HOLD = 2;
   localparam int SUBC = DIV / 16;
   localparam int FR   = 8 * DIV;

   logic        clk, rst_n;
   logic [3:0]  bright;
   logic        blank_lz;
   logic [31:0] live_bcd, msg_bcd;
   logic [7:0]  live_dots, msg_dots;
   logic        msg_req;
   logic        msg_ack, msg_busy, frame_tick;
   logic [7:0]  ss_value, ss_select;

   ss_display_ctrl #(.REFRESH_DIV(DIV), .HOLD_FRAMES(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .bright(bright), .blank_lz(blank_lz),
      .live_bcd(live_bcd), .live_dots(live_dots), .msg_req(msg_req),
      .msg_bcd(msg_bcd), .msg_dots(msg_dots), .msg_ack(msg_ack),
      .msg_busy(msg_busy), .frame_tick(frame_tick), .ss_value(ss_value),
      .ss_select(ss_select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: time since reset plus a message bookkeeping of pending/frames left.
   int          t;
   logic [31:0] m_snap_bcd, m_buf_bcd;
   logic [7:0]  m_snap_dots, m_buf_dots;
   bit          m_pending, m_ack_prev;
   int          m_left;
   logic [7:0]  e_sel, e_val;
   bit          e_ack;
   logic [6:0]  seg_on [16];

   initial begin
      seg_on[0]  = 7'h3F; seg_on[1]  = 7'h06; seg_on[2]  = 7'h5B; seg_on[3]  = 7'h4F;
      seg_on[4]  = 7'h66; seg_on[5]  = 7'h6D; seg_on[6]  = 7'h7D; seg_on[7]  = 7'h07;
      seg_on[8]  = 7'h7F; seg_on[9]  = 7'h6F; seg_on[10] = 7'h77; seg_on[11] = 7'h7C;
      seg_on[12] = 7'h39; seg_on[13] = 7'h5E; seg_on[14] = 7'h79; seg_on[15] = 7'h71;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
      end
   endtask

   task automatic model_reset();
      t = 0; m_snap_bcd = '0; m_snap_dots = '0;
      m_pending = 0; m_ack_prev = 0; m_left = 0;
      e_sel = 8'hFF; e_val = 8'hFF; e_ack = 0;
   endtask

   task automatic model_edge();
      int d, p;
      bit bnd, take, lit, blank;
      logic [3:0] nib;
      d     = (t / DIV) % 8;
      p     = t % DIV;
      bnd   = (t % FR) == FR - 1;
      lit   = p < (int'(bright) + 1) * SUBC;
      nib   = m_snap_bcd[4*d +: 4];
      blank = blank_lz && d > 0 && ((m_snap_bcd >> (4*d)) == 0) && ((m_snap_dots >> d) == 0);
      e_sel = lit ? ~(8'd1 << d) : 8'hFF;
      e_val = (!lit || blank) ? 8'hFF : {~m_snap_dots[d], ~seg_on[nib]};
      take  = msg_req && !m_ack_prev;
      e_ack = take;
      m_ack_prev = take;
      if (bnd) begin
         if (take) begin
            if (m_pending || m_left > 0) begin m_snap_bcd = m_buf_bcd; m_snap_dots = m_buf_dots; end
            else begin m_snap_bcd = live_bcd; m_snap_dots = live_dots; end
         end else if (m_pending) begin
            m_pending = 0; m_left = HOLD;
            m_snap_bcd = m_buf_bcd; m_snap_dots = m_buf_dots;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left > 0) begin m_snap_bcd = m_buf_bcd; m_snap_dots = m_buf_dots; end
            else begin m_snap_bcd = live_bcd; m_snap_dots = live_dots; end
         end else begin
            m_snap_bcd = live_bcd; m_snap_dots = live_dots;
         end
      end
      if (take) begin
         m_buf_bcd = msg_bcd; m_buf_dots = msg_dots;
         m_pending = 1; m_left = 0;
      end
      t++;
   endtask

   task automatic check_all();
      chk("ss_select",  ss_select, e_sel);
      chk("ss_value",   ss_value,  e_val);
      chk("msg_ack",    {7'd0, msg_ack},    {7'd0, e_ack});
      chk("msg_busy",   {7'd0, msg_busy},   {7'd0, (m_pending || m_left > 0)});
      chk("frame_tick", {7'd0, frame_tick}, {7'd0, ((t % FR) == FR - 1)});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Entered about 1 time unit after a rising edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      repeat (3) @(posedge clk);
      #1 check_all();
      #2 rst_n = 1'b1;
   endtask

   task automatic send_msg(input logic [31:0] b, input logic [7:0] d, input int extra);
      msg_bcd = b; msg_dots = d; msg_req = 1'b1;
      step();
      run(extra);
      msg_req = 1'b0;
      msg_bcd = $urandom; msg_dots = 8'($urandom);
   endtask

   task automatic align_boundary();
      for (int k = 0; k < FR && (t % FR) != FR - 1; k++) step();
   endtask

   initial begin
      rst_n = 1'b1; msg_req = 1'b0; blank_lz = 1'b0; bright = 4'd15;
      live_bcd = 32'h76543210; live_dots = 8'h01;
      msg_bcd = 32'd0; msg_dots = 8'd0;
      model_reset();
      #1;
      do_reset();

      // Full-brightness scan over two frames, then a mid-scan reset
      run(2 * FR + 5);
      run(37);
      do_reset();
      run(FR + 3);

      // PWM levels
      bright = 4'd3;  run(FR);
      bright = 4'd0;  run(FR);
      for (int k = 0; k < 4; k++) begin
         bright = 4'($urandom); run(DIV * 3);
      end
      bright = 4'd15;

      // Single message, held exactly HOLD frames
      send_msg(32'h11111111, 8'h00, 0);
      run(4 * FR);

      // Leading-zero blanking
      blank_lz = 1'b1; live_bcd = 32'h00000500; live_dots = 8'h00;
      run(2 * FR);
      live_dots = 8'h40;
      run(2 * FR);
      live_bcd = 32'h00000000; live_dots = 8'h00;
      run(2 * FR);
      blank_lz = 1'b0; live_bcd = 32'h89ABCDEF; live_dots = 8'hA5;

      // Replacement during display, with the request held into the ack cycle
      send_msg(32'h22222222, 8'h0F, 1);
      run(FR + FR / 2);
      send_msg(32'h33333333, 8'hF0, 1);
      run(4 * FR);

      // Request coincident with a frame boundary, from LIVE and from MSG_SHOW
      align_boundary();
      send_msg(32'h44444444, 8'h11, 0);
      run(FR + 20);
      align_boundary();
      send_msg(32'h55555555, 8'h22, 0);
      run(4 * FR);

      // Reset while a message is pending
      send_msg(32'h66666666, 8'h33, 0);
      run(10);
      do_reset();
      run(2 * FR);

      // Randomized traffic
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            live_bcd = $urandom; live_dots = 8'($urandom);
         end
         if ($urandom_range(0, 299) == 0) bright = 4'($urandom);
         if ($urandom_range(0, 499) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 249) == 0)
            send_msg($urandom, 8'($urandom), int'($urandom_range(0, 1)));
         else
            step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
